// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: ALU operation encodings,
// RV32 opcode constants, the controller state enum and the decoded instruction class.
package ctrl_pkg;

  // ALUctrl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Supported RV32 major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsImm,
    ClsLoad,
    ClsStore,
    ClsBeq,
    ClsBne,
    ClsIllegal
  } instr_cls_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B-format immediate selected by the
// decoded instruction class. R-type and illegal instructions yield zero.
// Ports:
//   instr_i  instruction bits [31:7] (opcode bits are not needed here)
//   cls_i    decoded instruction class
//   imm_o    sign-extended immediate, DATAWIDTH bits
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [31:7]          instr_i,
  input  instr_cls_e           cls_i,
  output logic [DATAWIDTH-1:0] imm_o
);

  logic sign;
  assign sign = instr_i[31];

  always_comb begin
    imm_o = '0;
    unique case (cls_i)
      ClsImm, ClsLoad: imm_o = {{(DATAWIDTH-12){sign}}, instr_i[31:20]};
      ClsStore:        imm_o = {{(DATAWIDTH-12){sign}}, instr_i[31:25], instr_i[11:7]};
      ClsBeq, ClsBne:  imm_o = {{(DATAWIDTH-13){sign}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
      default:         imm_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for an RV32 subset (ADD/SUB/AND/OR/ADDI/LW/SW/BEQ/BNE).
// Accepts one instruction per valid/ready handshake, decodes it, and sequences
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] with one PC update per instruction.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready/instr  fetch handshake (ready only in FETCH)
//   Eq                    ALU equality flag used to resolve branches in EXEC
//   mem_ready             data memory access completion
//   ALUctrl/ALUsrc/ImmOp  ALU control, registered in DECODE
//   rs1/rs2/rd            register addresses, registered in DECODE
//   RegWrite/MemRead/MemWrite/ResultSrc  datapath strobes
//   PCwrite/PCsrc         PC update strobe and source select
//   illegal               one-cycle pulse on an undecodable instruction
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [DATAWIDTH-1:0] instr,
  input  logic                 Eq,
  input  logic                 mem_ready,
  output logic [2:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic [DATAWIDTH-1:0] ImmOp,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 ResultSrc,
  output logic                 PCwrite,
  output logic                 PCsrc,
  output logic                 illegal
);

  state_e                 state_q, state_d;
  instr_cls_e             cls_q, cls_d;
  logic [31:0]            ir_q, ir_d;
  logic [2:0]             alu_ctrl_q, alu_ctrl_d;
  logic                   alu_src_q, alu_src_d;
  logic [DATAWIDTH-1:0]   imm_q, imm_d;
  logic [4:0]             rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  // Keeps instr_ready low until the first clock edge after reset release.
  logic                   ready_q;

  logic                   reg_write, mem_read, mem_write, result_src;
  logic                   pc_write, pc_src, illegal_pulse;

  // Decode of the instruction register
  instr_cls_e             dec_cls;
  logic [2:0]             dec_alu_ctrl;
  logic                   dec_alu_src;
  logic [DATAWIDTH-1:0]   dec_imm;
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [6:0]             funct7;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  always_comb begin
    dec_cls      = ClsIllegal;
    dec_alu_ctrl = ALU_ADD;
    dec_alu_src  = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin dec_cls = ClsR; dec_alu_ctrl = ALU_ADD; end
            3'b111: begin dec_cls = ClsR; dec_alu_ctrl = ALU_AND; end
            3'b110: begin dec_cls = ClsR; dec_alu_ctrl = ALU_OR;  end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_cls      = ClsR;
          dec_alu_ctrl = ALU_SUB;
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          dec_cls     = ClsImm;
          dec_alu_src = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          dec_cls     = ClsLoad;
          dec_alu_src = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          dec_cls     = ClsStore;
          dec_alu_src = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          dec_cls      = ClsBeq;
          dec_alu_ctrl = ALU_SUB;
        end else if (funct3 == 3'b001) begin
          dec_cls      = ClsBne;
          dec_alu_ctrl = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  imm_gen #(
    .DATAWIDTH(DATAWIDTH)
  ) u_imm_gen (
    .instr_i(ir_q[31:7]),
    .cls_i  (dec_cls),
    .imm_o  (dec_imm)
  );

  // Next-state and strobe logic
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    ir_d          = ir_q;
    alu_ctrl_d    = alu_ctrl_q;
    alu_src_d     = alu_src_q;
    imm_d         = imm_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    result_src    = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    illegal_pulse = 1'b0;

    case (state_q)
      StFetch: begin
        if (instr_valid && ready_q) begin
          ir_d    = instr[31:0];
          state_d = StDecode;
        end
      end
      StDecode: begin
        cls_d      = dec_cls;
        alu_ctrl_d = dec_alu_ctrl;
        alu_src_d  = dec_alu_src;
        imm_d      = dec_imm;
        rs1_d      = ir_q[19:15];
        rs2_d      = ir_q[24:20];
        rd_d       = ir_q[11:7];
        if (dec_cls == ClsIllegal) begin
          // Skip the instruction: advance PC sequentially and refetch.
          illegal_pulse = 1'b1;
          pc_write      = 1'b1;
          state_d       = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls_q)
          ClsLoad, ClsStore: state_d = StMem;
          ClsBeq: begin
            pc_write = 1'b1;
            pc_src   = Eq;
            state_d  = StFetch;
          end
          ClsBne: begin
            pc_write = 1'b1;
            pc_src   = ~Eq;
            state_d  = StFetch;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        mem_read  = (cls_q == ClsLoad);
        mem_write = (cls_q == ClsStore);
        if (mem_ready) begin
          if (cls_q == ClsStore) begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_write  = (rd_q != 5'd0);
        result_src = (cls_q == ClsLoad);
        pc_write   = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      cls_q      <= ClsR;
      ir_q       <= '0;
      alu_ctrl_q <= ALU_ADD;
      alu_src_q  <= 1'b0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      ir_q       <= ir_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_src_q  <= alu_src_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ready_q    <= 1'b1;
    end
  end

  assign instr_ready = ready_q && (state_q == StFetch);
  assign ALUctrl     = alu_ctrl_q;
  assign ALUsrc      = alu_src_q;
  assign ImmOp       = imm_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign RegWrite    = reg_write;
  assign MemRead     = mem_read;
  assign MemWrite    = mem_write;
  assign ResultSrc   = result_src;
  assign PCwrite     = pc_write;
  assign PCsrc       = pc_src;
  assign illegal     = illegal_pulse;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: drives hand-encoded RV32 instructions
// and compares strobes and decoded fields cycle by cycle against fixed values.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        Eq;
  logic        mem_ready;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [31:0] ImmOp;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, MemRead, MemWrite, ResultSrc, PCwrite, PCsrc, illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .DATAWIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .Eq         (Eq),
    .mem_ready  (mem_ready),
    .ALUctrl    (ALUctrl),
    .ALUsrc     (ALUsrc),
    .ImmOp      (ImmOp),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ResultSrc  (ResultSrc),
    .PCwrite    (PCwrite),
    .PCsrc      (PCsrc),
    .illegal    (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in FETCH and complete the handshake; returns in DECODE.
  task automatic fetch(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    #1;
    chk("fetch_ready", {31'd0, instr_ready}, 32'd1);
    chk("fetch_pcw", {31'd0, PCwrite}, 32'd0);
    tick();
    instr_valid = 1'b0;
  endtask

  int acc;
  int pcw;
  int rgw;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; Eq = 1'b0; mem_ready = 1'b0;
    #12;
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_pcw", {31'd0, PCwrite}, 32'd0);
    chk("rst_aluctrl", {29'd0, ALUctrl}, 32'd0);
    chk("rst_imm", ImmOp, 32'd0);
    chk("rst_regw", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("rel_ready_after_edge", {31'd0, instr_ready}, 32'd1);

    // ADD x3,x1,x2
    fetch(32'h002081B3);
    chk("add_dec_pcw", {31'd0, PCwrite}, 32'd0);
    chk("add_dec_ready", {31'd0, instr_ready}, 32'd0);
    chk("add_dec_illegal", {31'd0, illegal}, 32'd0);
    tick();
    chk("add_ex_aluctrl", {29'd0, ALUctrl}, 32'd0);
    chk("add_ex_alusrc", {31'd0, ALUsrc}, 32'd0);
    chk("add_ex_rd", {27'd0, rd}, 32'd3);
    chk("add_ex_rs1", {27'd0, rs1}, 32'd1);
    chk("add_ex_rs2", {27'd0, rs2}, 32'd2);
    chk("add_ex_imm", ImmOp, 32'd0);
    chk("add_ex_regw", {31'd0, RegWrite}, 32'd0);
    chk("add_ex_pcw", {31'd0, PCwrite}, 32'd0);
    tick();
    chk("add_wb_regw", {31'd0, RegWrite}, 32'd1);
    chk("add_wb_pcw", {31'd0, PCwrite}, 32'd1);
    chk("add_wb_pcsrc", {31'd0, PCsrc}, 32'd0);
    chk("add_wb_ressrc", {31'd0, ResultSrc}, 32'd0);
    tick();
    chk("add_done_ready", {31'd0, instr_ready}, 32'd1);
    chk("add_done_pcw", {31'd0, PCwrite}, 32'd0);

    // ADDI x5,x0,-1
    fetch(32'hFFF00293);
    tick();
    chk("addi_ex_imm", ImmOp, 32'hFFFFFFFF);
    chk("addi_ex_alusrc", {31'd0, ALUsrc}, 32'd1);
    chk("addi_ex_aluctrl", {29'd0, ALUctrl}, 32'd0);
    chk("addi_ex_rd", {27'd0, rd}, 32'd5);
    tick();
    chk("addi_wb_regw", {31'd0, RegWrite}, 32'd1);
    chk("addi_wb_pcw", {31'd0, PCwrite}, 32'd1);
    tick();

    // ADDI x0,x0,5: write to x0 is suppressed
    fetch(32'h00500013);
    tick();
    chk("addi0_ex_imm", ImmOp, 32'd5);
    tick();
    chk("addi0_wb_regw", {31'd0, RegWrite}, 32'd0);
    chk("addi0_wb_pcw", {31'd0, PCwrite}, 32'd1);
    tick();

    // BEQ x1,x2,+8
    fetch(32'h00208463);
    tick();
    Eq = 1'b1;
    #1;
    chk("beq_ex_imm", ImmOp, 32'd8);
    chk("beq_ex_aluctrl", {29'd0, ALUctrl}, 32'd1);
    chk("beq_ex_alusrc", {31'd0, ALUsrc}, 32'd0);
    chk("beq_ex_pcw", {31'd0, PCwrite}, 32'd1);
    chk("beq_ex_pcsrc_eq1", {31'd0, PCsrc}, 32'd1);
    Eq = 1'b0;
    #1;
    chk("beq_ex_pcsrc_eq0", {31'd0, PCsrc}, 32'd0);
    chk("beq_ex_regw", {31'd0, RegWrite}, 32'd0);
    tick();
    chk("beq_done_ready", {31'd0, instr_ready}, 32'd1);
    chk("beq_done_pcw", {31'd0, PCwrite}, 32'd0);

    // BNE x1,x2,+8 with Eq=1: not taken, 3 cycles total
    fetch(32'h00209463);
    chk("bne_dec_pcw", {31'd0, PCwrite}, 32'd0);
    tick();
    Eq = 1'b1;
    #1;
    chk("bne_ex_pcw", {31'd0, PCwrite}, 32'd1);
    chk("bne_ex_pcsrc", {31'd0, PCsrc}, 32'd0);
    Eq = 1'b0;
    tick();
    chk("bne_done_ready", {31'd0, instr_ready}, 32'd1);

    // LW x4,12(x1) with mem_ready low for three cycles
    fetch(32'h00C0A203);
    tick();
    chk("lw_ex_imm", ImmOp, 32'd12);
    chk("lw_ex_alusrc", {31'd0, ALUsrc}, 32'd1);
    chk("lw_ex_memrd", {31'd0, MemRead}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("lw_mem_wait_rd", {31'd0, MemRead}, 32'd1);
      chk("lw_mem_wait_pcw", {31'd0, PCwrite}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_mem_done_rd", {31'd0, MemRead}, 32'd1);
    chk("lw_mem_done_regw", {31'd0, RegWrite}, 32'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("lw_wb_ressrc", {31'd0, ResultSrc}, 32'd1);
    chk("lw_wb_regw", {31'd0, RegWrite}, 32'd1);
    chk("lw_wb_pcw", {31'd0, PCwrite}, 32'd1);
    chk("lw_wb_memrd", {31'd0, MemRead}, 32'd0);
    tick();

    // SW x2,8(x1) with immediate completion
    fetch(32'h0020A423);
    tick();
    chk("sw_ex_imm", ImmOp, 32'd8);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("sw_mem_wr", {31'd0, MemWrite}, 32'd1);
    chk("sw_mem_pcw", {31'd0, PCwrite}, 32'd1);
    chk("sw_mem_pcsrc", {31'd0, PCsrc}, 32'd0);
    chk("sw_mem_regw", {31'd0, RegWrite}, 32'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("sw_done_wr", {31'd0, MemWrite}, 32'd0);
    chk("sw_done_ready", {31'd0, instr_ready}, 32'd1);

    // Illegal instruction
    fetch(32'hFFFFFFFF);
    chk("ill_dec_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_dec_pcw", {31'd0, PCwrite}, 32'd1);
    chk("ill_dec_pcsrc", {31'd0, PCsrc}, 32'd0);
    tick();
    chk("ill_after_pulse", {31'd0, illegal}, 32'd0);
    chk("ill_after_ready", {31'd0, instr_ready}, 32'd1);

    // Reset asserted during MEM
    fetch(32'h00C0A203);
    tick();
    tick();
    #1;
    chk("rstmem_pre_rd", {31'd0, MemRead}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmem_rd", {31'd0, MemRead}, 32'd0);
    chk("rstmem_imm", ImmOp, 32'd0);
    chk("rstmem_rd_addr", {27'd0, rd}, 32'd0);
    chk("rstmem_ready", {31'd0, instr_ready}, 32'd0);
    chk("rstmem_pcw", {31'd0, PCwrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstmem_rel_ready", {31'd0, instr_ready}, 32'd1);

    // Back-to-back ADDs with instr_valid held high: one accept, one PCwrite per 4 cycles
    acc = 0; pcw = 0; rgw = 0;
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (instr_valid && instr_ready) acc++;
      if (PCwrite) pcw++;
      if (RegWrite) rgw++;
      tick();
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", acc, 32'd5);
    chk("b2b_pcwrites", pcw, 32'd5);
    chk("b2b_regwrites", rgw, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
